// File: rtl/im_loader_pkg.sv
// Shared instruction-memory definitions used by the PC, the IM and the IM loader.
package im_loader_pkg;

  localparam int IM_ADDR_WIDTH = 10;
  localparam int INSTR_WIDTH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/im_write_stage.sv
// Registered driver for the instruction-memory write port (en_write/address/data_in).
module im_write_stage #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vld_p0,
  input  logic [ADDR_WIDTH-1:0] addr_p0,
  input  logic [DATA_WIDTH-1:0] data_p0,
  output logic                  en_write,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_in
);

  // p0 -> p1: one register stage; the IM commits on the edge after this
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_write <= 1'b0;
      address  <= '0;
      data_in  <= '0;
    end else begin
      en_write <= vld_p0;
      if (vld_p0) begin
        address <= addr_p0;
        data_in <= data_p0;
      end
    end
  end

endmodule

// File: rtl/im_loader.sv
// IM write-side master: streams words into consecutive IM addresses, stalls the PC
// while loading and pulses a PC reset once the full image is in place.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = IM_ADDR_WIDTH,
  parameter int DATA_WIDTH = INSTR_WIDTH,
  parameter int START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  im_en_write,
  output logic [ADDR_WIDTH-1:0] im_address,
  output logic [DATA_WIDTH-1:0] im_data_in,
  output logic                  cpu_hold,
  output logic                  pc_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH+1:0] CAPACITY  = (ADDR_WIDTH+2)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH+1:0] START_EXT = (ADDR_WIDTH+2)'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] START_A   = ADDR_WIDTH'(START_ADDR);

  ld_state_t             state, state_nxt;
  logic [ADDR_WIDTH:0]   count, count_nxt;
  logic [ADDR_WIDTH:0]   len, len_nxt;
  logic                  err_nxt, fin_nxt;
  logic                  len_ok, accept, last;
  logic [ADDR_WIDTH-1:0] addr_p0;

  // Range check is done one bit wider so START_ADDR+length cannot wrap.
  assign len_ok   = (length != '0) && ((START_EXT + {1'b0, length}) <= CAPACITY);
  assign in_ready = (state == ST_LOAD);
  assign accept   = in_ready && in_valid;
  assign last     = ((count + 1'b1) == len);
  assign addr_p0  = START_A + count[ADDR_WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    len_nxt   = len;
    err_nxt   = 1'b0;
    fin_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_nxt = ST_LOAD;
            len_nxt   = length;
            count_nxt = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (accept) count_nxt = count + 1'b1;
        // Abort beats a simultaneous last-word accept; that word is still written.
        if (abort) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end else if (accept && last) begin
          state_nxt = ST_RELEASE;
          fin_nxt   = 1'b1;
        end
      end
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      len      <= '0;
      error    <= 1'b0;
      done     <= 1'b0;
      pc_reset <= 1'b0;
      cpu_hold <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      len      <= len_nxt;
      error    <= err_nxt;
      done     <= fin_nxt;
      pc_reset <= fin_nxt;
      cpu_hold <= (state_nxt != ST_IDLE);
    end
  end

  im_write_stage #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_write_stage (
    .clk      (clk),
    .reset    (reset),
    .vld_p0   (accept),
    .addr_p0  (addr_p0),
    .data_p0  (in_data),
    .en_write (im_en_write),
    .address  (im_address),
    .data_in  (im_data_in)
  );

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
Write-side master for the instruction memory. It accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them to consecutive IM addresses through the IM write port (en_write/address/data_in). While loading, it holds the PC stalled. When the load completes, it pulses a PC reset so fetch restarts at address 0. The IM read path is the PC fetch; this block is the only IM writer.

Parameters:
ADDR_WIDTH, 10, IM address width; capacity is 2^ADDR_WIDTH words.
DATA_WIDTH, 16, instruction word width.
START_ADDR, 0, IM address of the first loaded word.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a load; sampled in IDLE only.
abort  input  1  cancels an in-progress load; sampled in LOAD only.
length  input  ADDR_WIDTH+1  number of words to load; sampled together with start.
in_valid  input  1  in_data holds a valid word.
in_data  input  DATA_WIDTH  instruction word.
in_ready  output  1  loader accepts a word this cycle.
im_en_write  output  1  IM write enable.
im_address  output  ADDR_WIDTH  IM write address.
im_data_in  output  DATA_WIDTH  IM write data.
cpu_hold  output  1  drives PC stall; high while busy.
pc_reset  output  1  one-cycle pulse that restarts the PC at 0 after a load.
done  output  1  one-cycle pulse when a load completes.
error  output  1  one-cycle pulse on a rejected start or an abort.

Behaviour:
- States: IDLE, LOAD, RELEASE. Reset value is IDLE.
- Every output is 0 under reset, including im_address and im_data_in. Reset clears all registers immediately, without waiting for clk.
- IDLE: in_ready=0, cpu_hold=0.
  - start=1 with 1 <= length <= 2^ADDR_WIDTH - START_ADDR: latch length, clear word counter, next state LOAD.
  - start=1 with length=0 or with START_ADDR+length > 2^ADDR_WIDTH: error=1 in the next cycle, stay in IDLE, nothing written.
- LOAD: in_ready=1, cpu_hold=1.
  - A word is accepted on a rising edge where in_valid && in_ready.
  - In the cycle after acceptance: im_en_write=1, im_address=START_ADDR+count, im_data_in=accepted word. The IM commits the word on the following edge, so latency from accept to IM commit is 1 cycle.
  - The counter increments on each accept. im_en_write is 0 in any cycle that does not follow an accept, so in_valid gaps produce no writes.
  - Accepting word number length (the last word): next state RELEASE, and in_ready drops in the same update.
- RELEASE (exactly 1 cycle): the write for the last word is active, plus cpu_hold=1, pc_reset=1, done=1. Next state is IDLE.
- abort=1 in LOAD:
  - Next state IDLE, error=1 pulse; no pc_reset and no done.
  - A word accepted on the same edge is still written in the following cycle.
  - Words already written stay in the IM.
- Simultaneous events:
  - start outside IDLE is ignored.
  - abort outside LOAD is ignored.
  - abort and the last-word accept on the same edge: abort wins (IDLE, error, last word still written).
- Reset asserted mid-load: im_en_write drops immediately, so no partial-cycle write survives. Previously committed IM words are unaffected.
- Address arithmetic: ADDR_WIDTH bits. The range check above guarantees no wrap-around. The counter is ADDR_WIDTH+1 bits so it can hold 2^ADDR_WIDTH.
- cpu_hold and pc_reset are registered outputs (glitch-free).

Decomposition:
- Shared package: state encoding (IDLE/LOAD/RELEASE), IM_ADDR_WIDTH=10, INSTR_WIDTH=16. The PC, the IM and this block all use these.
- Sub-module: im_write_stage, the registered write-port driver (en_write/address/data_in). It is shared with any future IM debug writer.
- FSM and counter stay in im_loader.

Test Plan:
- Reset, then start with length=4 and in_valid held high with data 16'h0011, 16'h0022, 16'h0033, 16'h0044 -> IM[0..3] hold those values; im_en_write is high for exactly 4 consecutive cycles; pc_reset and done pulse once in the cycle of the 4th write; the PC then fetches 16'h0011 at address 0.
- Same load as above, but in_valid low for 2 cycles between words 2 and 3 -> no writes during the gap; IM contents identical to the first scenario; cpu_hold stays high throughout.
- start with length=0, then with length=1025 -> error pulses once for each; im_en_write never goes high; state stays IDLE.
- length=8, abort after 3 accepts -> IM[0..2] written, IM[3] unchanged, error pulses once, no pc_reset, cpu_hold low the next cycle.
- length=8, reset asserted for 50 ns mid-cycle after 5 accepts -> all outputs 0 immediately; a new start with length=2 rewrites IM[0..1] correctly.
- Load exactly 1024 words with START_ADDR=0 -> the last write goes to address 10'h3FF; done pulses; no error.
